// File: rtl/crack_sched.sv
// Key-search scheduler: hands out fixed-size key chunks to a pool of crack cores,
// catches the first reported hit, aborts the remaining cores and reports the result.
module crack_sched #(
    parameter int unsigned N_CORES = 2,
    parameter int unsigned CHUNK_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    rdy,
    output logic [23:0]             key,
    output logic                    key_valid,
    output logic [N_CORES-1:0]      core_start,
    output logic [24*N_CORES-1:0]   core_base,
    output logic [N_CORES-1:0]      core_abort,
    input  logic [N_CORES-1:0]      core_done,
    input  logic [N_CORES-1:0]      core_found,
    input  logic [24*N_CORES-1:0]   core_key
);

    // One extra bit so the chunk count itself is representable.
    localparam int unsigned          CNT_W   = 24 - CHUNK_W + 1;
    localparam logic [CNT_W-1:0]     NCHUNKS = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_CORES-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]     next_q, next_d;
    logic                 found_q, found_d;
    logic [23:0]          key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [N_CORES-1:0]   abort_q, abort_d;
    logic [23:0]          base_q [N_CORES];
    logic [23:0]          base_d [N_CORES];

    logic [N_CORES-1:0]   start_sel;
    logic                 idle_avail;
    logic [N_CORES-1:0]   hits;
    logic [23:0]          hit_key;
    logic                 hit_taken;
    logic                 can_dispatch;
    logic [23:0]          base_new;

    assign base_new = {next_q[CNT_W-2:0], {CHUNK_W{1'b0}}};
    assign hits     = core_done & core_found & busy_q;

    // Lowest-indexed idle core; a core freed by core_done this cycle is still busy_q.
    always_comb begin
        start_sel  = '0;
        idle_avail = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (!busy_q[i] && !idle_avail) begin
                start_sel[i] = 1'b1;
                idle_avail   = 1'b1;
            end
        end
    end

    always_comb begin
        hit_key   = '0;
        hit_taken = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (hits[i] && !hit_taken) begin
                hit_key   = core_key[24*i +: 24];
                hit_taken = 1'b1;
            end
        end
    end

    assign can_dispatch = (state_q == RUN) && !found_q && (next_q < NCHUNKS) && idle_avail;
    assign core_start   = can_dispatch ? start_sel : '0;

    // A freshly started core shows its new base in the start cycle itself.
    always_comb begin
        core_base = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            core_base[24*i +: 24] = core_start[i] ? base_new : base_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        next_d      = next_q;
        found_d     = found_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        abort_d     = '0;
        base_d      = base_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = RUN;
                    busy_d      = '0;
                    next_d      = '0;
                    found_d     = 1'b0;
                    key_valid_d = 1'b0;
                end
            end
            RUN: begin
                busy_d = (busy_q & ~core_done) | core_start;
                if (can_dispatch) begin
                    next_d = next_q + CNT_W'(1);
                end
                for (int unsigned i = 0; i < N_CORES; i++) begin
                    if (core_start[i]) begin
                        base_d[i] = base_new;
                    end
                end
                if (hit_taken) begin
                    found_d = 1'b1;
                    key_d   = hit_key;
                    // A core started alongside the hit is busy too and gets stopped.
                    abort_d = (busy_q & ~core_done) | core_start;
                    state_d = DRAIN;
                end else if ((next_q == NCHUNKS) && (busy_q == '0)) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                busy_d = busy_q & ~core_done;
                if (busy_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                key_valid_d = found_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            next_q      <= '0;
            found_q     <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            abort_q     <= '0;
            base_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            next_q      <= next_d;
            found_q     <= found_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            abort_q     <= abort_d;
            base_q      <= base_d;
        end
    end

    assign rdy        = (state_q == IDLE);
    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign core_abort = abort_q;

endmodule

// File: tb/tb_crack_sched.sv
// Scoreboard bench for crack_sched: behavioural crack cores drive the DUT, expected
// dispatches/aborts/results are queued by the stimulus and popped by monitors.
`timescale 1ns/1ps
module tb_crack_sched;

    localparam int NC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, en;
    logic              rdy, key_valid;
    logic [23:0]       key;
    logic [NC-1:0]     core_start, core_abort;
    logic [24*NC-1:0]  core_base;
    logic [NC-1:0]     cdone, cfound;
    logic [24*NC-1:0]  ckey;

    logic              en_b, rdy_b, kv_b, start_b, abort_b, cdone_b, cfound_b;
    logic [23:0]       key_b, base_b, ckey_b;

    crack_sched #(.N_CORES(2), .CHUNK_W(20)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
        .core_start(core_start), .core_base(core_base), .core_abort(core_abort),
        .core_done(cdone), .core_found(cfound), .core_key(ckey)
    );

    crack_sched #(.N_CORES(1), .CHUNK_W(23)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b), .key_valid(kv_b),
        .core_start(start_b), .core_base(base_b), .core_abort(abort_b),
        .core_done(cdone_b), .core_found(cfound_b), .core_key(ckey_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_disp[$];
    logic [31:0] exp_abort[$];
    logic [31:0] exp_res[$];
    logic [31:0] exp_disp_b[$];
    logic [31:0] exp_res_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Core model configuration
    int          dly     [NC];
    logic        hit_en  [NC];
    logic [23:0] hit_base[NC];
    logic [23:0] hit_kcfg[NC];
    int          cnt     [NC];
    logic [23:0] cur_base[NC];
    int          cnt_b;

    always @(negedge clk) begin
        for (int i = 0; i < NC; i++) begin
            cdone[i]  = 1'b0;
            cfound[i] = 1'b0;
            if (rst) begin
                cnt[i] = 0;
            end else begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        cdone[i]  = 1'b1;
                        cfound[i] = hit_en[i] && (cur_base[i] == hit_base[i]);
                        ckey[24*i +: 24] = cfound[i] ? hit_kcfg[i] : (24'hDEAD00 | 24'(i));
                    end
                end
                if (core_start[i]) begin
                    cnt[i]      = dly[i];
                    cur_base[i] = core_base[24*i +: 24];
                end
                if (core_abort[i] && cnt[i] > 0) cnt[i] = 1;
            end
        end
    end

    always @(negedge clk) begin
        cdone_b  = 1'b0;
        cfound_b = 1'b0;
        if (rst) begin
            cnt_b = 0;
        end else begin
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) cdone_b = 1'b1;
            end
            if (start_b) cnt_b = 4;
        end
    end

    logic rdy_prev = 1'b1;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    if (exp_disp.size() != 0) e = exp_disp.pop_front(); else e = '1;
                    check("dispatch", {8'(i), core_base[24*i +: 24]}, e);
                end
            end
            if (core_abort != '0) begin
                if (exp_abort.size() != 0) e = exp_abort.pop_front(); else e = '1;
                check("abort", {30'd0, core_abort}, e);
            end
            if (rdy && !rdy_prev) begin
                if (exp_res.size() != 0) e = exp_res.pop_front(); else e = '1;
                check("result", {7'd0, key_valid, key}, e);
            end
        end
        rdy_prev = rst ? 1'b1 : rdy;
    end

    logic rdy_prev_b = 1'b1;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (start_b) begin
                if (exp_disp_b.size() != 0) e = exp_disp_b.pop_front(); else e = '1;
                check("dispatch_b", {8'd0, base_b}, e);
            end
            if (abort_b) check("abort_b", 32'd1, 32'd0);
            if (rdy_b && !rdy_prev_b) begin
                if (exp_res_b.size() != 0) e = exp_res_b.pop_front(); else e = '1;
                check("result_b", {7'd0, kv_b, key_b}, e);
            end
        end
        rdy_prev_b = rst ? 1'b1 : rdy_b;
    end

    task automatic cfg(input int d0, input int d1, input logic h0, input logic h1,
                       input logic [23:0] b0, input logic [23:0] b1,
                       input logic [23:0] k0, input logic [23:0] k1);
        dly[0] = d0; dly[1] = d1;
        hit_en[0] = h0; hit_en[1] = h1;
        hit_base[0] = b0; hit_base[1] = b1;
        hit_kcfg[0] = k0; hit_kcfg[1] = k1;
    endtask

    task automatic push_full_run();
        for (int i = 0; i < 16; i++) exp_disp.push_back({8'(i % 2), 24'(i) << 20});
    endtask

    task automatic pulse_en();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int k = 0;
        while (exp_res.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        check({name, " timeout"}, 32'(exp_res.size()), 32'd0);
        check({name, " leftover dispatch"}, 32'(exp_disp.size()), 32'd0);
        check({name, " leftover abort"}, 32'(exp_abort.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_b = 1'b0;
        ckey = '0; ckey_b = 24'h0BAD0B;
        cfg(5, 5, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rdy", {31'd0, rdy}, 32'd1);
        check("rst key_valid", {31'd0, key_valid}, 32'd0);
        check("rst key", {8'd0, key}, 32'd0);
        check("rst start/abort", {28'd0, core_start, core_abort}, 32'd0);
        check("rst base", 32'(core_base), 32'd0);
        check("rst rdy_b", {31'd0, rdy_b}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Hit on core 1 while core 0 busy; core 0's late hit during DRAIN ignored
        cfg(8, 3, 1'b1, 1'b1, 24'h000000, 24'h100000, 24'h0BAD00, 24'h1A2B3C);
        exp_disp.push_back({8'd0, 24'h000000});
        exp_disp.push_back({8'd1, 24'h100000});
        exp_abort.push_back(32'h1);
        exp_res.push_back({7'd0, 1'b1, 24'h1A2B3C});
        pulse_en();
        wait_result("hit_core1");

        // Full sweep without a hit; en pokes while busy must be ignored
        cfg(5, 5, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0);
        push_full_run();
        exp_res.push_back({7'd0, 1'b0, 24'h1A2B3C});
        pulse_en();
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        wait_result("no_hit");

        // Simultaneous hits: lowest index wins, nobody left to abort
        cfg(6, 5, 1'b1, 1'b1, 24'h000000, 24'h100000, 24'h000010, 24'h100020);
        exp_disp.push_back({8'd0, 24'h000000});
        exp_disp.push_back({8'd1, 24'h100000});
        exp_res.push_back({7'd0, 1'b1, 24'h000010});
        pulse_en();
        wait_result("dual_hit");

        // Reset in the middle of a search with both cores busy
        cfg(5, 5, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0);
        exp_disp.push_back({8'd0, 24'h000000});
        exp_disp.push_back({8'd1, 24'h100000});
        pulse_en();
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst rdy", {31'd0, rdy}, 32'd1);
        check("midrst key_valid", {31'd0, key_valid}, 32'd0);
        check("midrst key", {8'd0, key}, 32'd0);
        check("midrst start/abort", {28'd0, core_start, core_abort}, 32'd0);
        check("midrst base", 32'(core_base), 32'd0);
        check("midrst dispatches", 32'(exp_disp.size()), 32'd0);
        push_full_run();
        exp_res.push_back({7'd0, 1'b0, 24'h000000});
        pulse_en();
        wait_result("restart");

        // Two-chunk configuration: exactly two dispatches, no wrap
        exp_disp_b.push_back({8'd0, 24'h000000});
        exp_disp_b.push_back({8'd0, 24'h800000});
        exp_res_b.push_back({7'd0, 1'b0, 24'h000000});
        @(posedge clk); #1 en_b = 1'b1;
        @(posedge clk); #1 en_b = 1'b0;
        for (int k = 0; k < 200 && exp_res_b.size() != 0; k++) @(posedge clk);
        check("b timeout", 32'(exp_res_b.size()), 32'd0);
        repeat (10) @(posedge clk);
        check("b leftover dispatch", 32'(exp_disp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/crack_sched.md
CRACK_SCHED -- requirements
Module: crack_sched

Interface
REQ-001 Parameter N_CORES, default 2: number of attached crack cores, range 1..8.
REQ-002 Parameter CHUNK_W, default 20: log2 of keys per chunk, range 8..23; NCHUNKS = 2^(24-CHUNK_W).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  start request; sampled only while rdy=1.
REQ-006 rdy  output  1  high when idle and able to accept en.
REQ-007 key  output  24  key found by the last search; held until the next accepted en.
REQ-008 key_valid  output  1  high when the last search found a key.
REQ-009 core_start  output  N_CORES  one-cycle start pulse per core.
REQ-010 core_base  output  24*N_CORES  first key of the chunk assigned to each core; slice i = [24*i+23:24*i].
REQ-011 core_abort  output  N_CORES  one-cycle stop pulse per core.
REQ-012 core_done  input  N_CORES  one-cycle pulse: the core finished or aborted its chunk.
REQ-013 core_found  input  N_CORES  qualifies core_done: the chunk contained a readable-plaintext key.
REQ-014 core_key  input  24*N_CORES  key reported with core_done/core_found.

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: rdy=1; en=1 -> RUN next cycle, rdy=0, key_valid=0, next_chunk=0, found=0, busy mask=0.
REQ-017 en while rdy=0 is ignored with no side effects.
REQ-018 next_chunk counter is (24-CHUNK_W+1) bits wide so NCHUNKS is representable without wrap.
REQ-019 RUN dispatch: when found=0, next_chunk<NCHUNKS and some core has busy=0 -> pulse core_start on the lowest-indexed idle core, drive core_base[i] = next_chunk<<CHUNK_W in the same cycle, set busy[i], increment next_chunk.
REQ-020 At most one dispatch per cycle; core_base[i] holds its value until the next dispatch to core i.
REQ-021 A core is idle in the cycle after its core_done, never in the same cycle.
REQ-022 Completion: core_done[i] clears busy[i]; core_done on a non-busy core is ignored.
REQ-023 First hit: core_done[i]&core_found[i] while found=0 latches key=core_key[i] and sets found; simultaneous hits -> lowest index wins.
REQ-024 Hits arriving while found=1 are ignored, including in DRAIN.
REQ-025 RUN -> DRAIN when found becomes 1: core_abort pulses for one cycle on every core still busy and not completing in that cycle.
REQ-026 DRAIN: no dispatch; wait until busy mask=0, then -> DONE.
REQ-027 RUN -> DONE when found=0, next_chunk=NCHUNKS and busy mask=0.
REQ-028 DONE: key_valid=found, rdy=1 on exit; -> IDLE next cycle.
REQ-029 Latency: en accepted at cycle t -> first core_start at t+1, then one per cycle to each idle core.
REQ-030 key keeps its previous value when a search ends without a hit.

Reset
REQ-031 rst=1 at any clock edge, including mid-search: state=IDLE, rdy=1, key_valid=0, key=0, core_start=0, core_abort=0, core_base=0, busy=0, next_chunk=0, found=0.
REQ-032 Cores are not aborted by this block on reset; the same rst drives them.

Verification
REQ-033 N_CORES=2, CHUNK_W=20, en pulse, no hits, cores respond with core_done 5 cycles after start -> bases 0x000000..0xF00000 each issued once, DONE with key_valid=0, rdy=1.
REQ-034 Core 1 reports found with key 0x1A2B3C on chunk 1 while core 0 is busy -> core_abort[0] pulses, DRAIN until core_done[0], key=0x1A2B3C, key_valid=1.
REQ-035 Both cores pulse core_done with core_found in the same cycle, keys 0x000010 and 0x100020 -> key=0x000010.
REQ-036 en asserted while rdy=0 -> no restart; next_chunk and core_base unaffected.
REQ-037 rst asserted mid-RUN with both cores busy -> all outputs at reset values next cycle; a new en restarts from base 0x000000.
REQ-038 CHUNK_W=23, N_CORES=1 -> exactly two dispatches, bases 0x000000 and 0x800000; no counter wrap.
